// File: rtl/tec_pwm_pkg.sv
// Shared types and helpers for the TEC H-bridge PWM driver.
// Holds the drive-state encoding, direction constants and the period-length function.
package tec_pwm_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      POS  = 2'd1,
      NEG  = 2'd2,
      DEAD = 2'd3
   } state_e;

   localparam logic DIR_HEAT = 1'b1;
   localparam logic DIR_COOL = 1'b0;

   // One count short of 2^width so that a full-scale magnitude means 100 % duty.
   function automatic int unsigned period_len(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter: counts 0..P-1 and wraps, flagging the
// last (boundary) cycle of each period.
module pwm_period_counter
   import tec_pwm_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_Clock,
   input  logic             i_Reset_n,
   output logic [WIDTH-1:0] o_Cnt,
   output logic             o_Boundary
);

   localparam int unsigned      P    = period_len(WIDTH);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(P - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end

   assign o_Cnt      = cnt_q;
   assign o_Boundary = (cnt_q == LAST);

endmodule

// File: rtl/tec_hbridge_pwm.sv
// Registered TEC H-bridge driver: double-buffered direction/magnitude command,
// period-aligned PWM and leg enables. Dead time on reversal when TEC_PWM_DEADTIME_EN is defined.
module tec_hbridge_pwm
   import tec_pwm_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEAD_CYCLES = 4
) (
   input  logic             i_Clock,
   input  logic             i_Reset_n,
   input  logic             i_Enable,
   input  logic             i_Cmd_DV,
   input  logic             i_Dir,
   input  logic [WIDTH-1:0] i_Mag,
   output logic             o_Pwm,
   output logic             o_H_Pos,
   output logic             o_H_Neg,
   output logic             o_Dead,
   output logic             o_Period_Start
);

   logic [WIDTH-1:0] cnt;
   logic             boundary;

   pwm_period_counter #(.WIDTH(WIDTH)) u_cnt (
      .i_Clock    (i_Clock),
      .i_Reset_n  (i_Reset_n),
      .o_Cnt      (cnt),
      .o_Boundary (boundary)
   );

   function automatic state_e leg_of(input logic dir);
      return (dir == DIR_HEAT) ? POS : NEG;
   endfunction

   // A WIDTH-bit magnitude tops out at 2^WIDTH-1 = P, so the clamp to P is inherent.
   logic             sh_dir_q, sh_dir_d, act_dir_q, act_dir_d;
   logic [WIDTH-1:0] sh_mag_q, sh_mag_d, act_mag_q, act_mag_d;
   state_e           state_q, state_d;
   logic             pwm_q, pwm_d, hpos_q, hpos_d, hneg_q, hneg_d, pstart_q, pstart_d;

`ifdef TEC_PWM_DEADTIME_EN
   localparam logic [WIDTH-1:0] DEAD_LOAD = WIDTH'(DEAD_CYCLES);
   logic [WIDTH-1:0] dead_q, dead_d;
   logic             dead_out_q, dead_out_d;
`else
   logic [31:0] unused_dead_cfg;
   assign unused_dead_cfg = DEAD_CYCLES;
`endif

   always_comb begin
      sh_dir_d  = i_Cmd_DV ? i_Dir : sh_dir_q;
      sh_mag_d  = i_Cmd_DV ? i_Mag : sh_mag_q;
      // A strobe in the boundary cycle goes straight to the active register.
      act_dir_d = boundary ? sh_dir_d : act_dir_q;
      act_mag_d = boundary ? sh_mag_d : act_mag_q;
   end

   always_comb begin
      state_d = state_q;
`ifdef TEC_PWM_DEADTIME_EN
      dead_d  = dead_q;
`endif
      if (!i_Enable) begin
         state_d = OFF;
`ifdef TEC_PWM_DEADTIME_EN
         dead_d  = '0;
`endif
      end else if (boundary) begin
         if (act_mag_d == '0) begin
            state_d = OFF;
         end else if ((state_q == POS || state_q == NEG) && leg_of(act_dir_d) != state_q) begin
`ifdef TEC_PWM_DEADTIME_EN
            if (DEAD_CYCLES == 0) begin
               state_d = leg_of(act_dir_d);
            end else begin
               state_d = DEAD;
               dead_d  = DEAD_LOAD;
            end
`else
            state_d = leg_of(act_dir_d);
`endif
         end else begin
            state_d = leg_of(act_dir_d);
         end
      end
`ifdef TEC_PWM_DEADTIME_EN
      else if (state_q == DEAD) begin
         if (dead_q <= WIDTH'(1)) begin
            state_d = leg_of(act_dir_q);
            dead_d  = '0;
         end else begin
            dead_d  = dead_q - WIDTH'(1);
         end
      end
`endif
   end

   // Outputs are gated by i_Enable directly so dropping it clears them on the next edge.
   always_comb begin
      hpos_d   = i_Enable && (state_q == POS);
      hneg_d   = i_Enable && (state_q == NEG);
      pwm_d    = i_Enable && (state_q == POS || state_q == NEG) && (cnt < act_mag_q);
      pstart_d = i_Enable && (cnt == '0);
`ifdef TEC_PWM_DEADTIME_EN
      dead_out_d = i_Enable && (state_q == DEAD);
`endif
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         sh_dir_q  <= 1'b0;
         sh_mag_q  <= '0;
         act_dir_q <= 1'b0;
         act_mag_q <= '0;
         state_q   <= OFF;
         pwm_q     <= 1'b0;
         hpos_q    <= 1'b0;
         hneg_q    <= 1'b0;
         pstart_q  <= 1'b0;
`ifdef TEC_PWM_DEADTIME_EN
         dead_q     <= '0;
         dead_out_q <= 1'b0;
`endif
      end else begin
         sh_dir_q  <= sh_dir_d;
         sh_mag_q  <= sh_mag_d;
         act_dir_q <= act_dir_d;
         act_mag_q <= act_mag_d;
         state_q   <= state_d;
         pwm_q     <= pwm_d;
         hpos_q    <= hpos_d;
         hneg_q    <= hneg_d;
         pstart_q  <= pstart_d;
`ifdef TEC_PWM_DEADTIME_EN
         dead_q     <= dead_d;
         dead_out_q <= dead_out_d;
`endif
      end
   end

   assign o_Pwm          = pwm_q;
   assign o_H_Pos        = hpos_q;
   assign o_H_Neg        = hneg_q;
   assign o_Period_Start = pstart_q;
`ifdef TEC_PWM_DEADTIME_EN
   assign o_Dead         = dead_out_q;
`else
   assign o_Dead         = 1'b0;
`endif

endmodule

// File: tb/tb_tec_hbridge_pwm.sv
// Directed bench for tec_hbridge_pwm with WIDTH=4 (P=15), DEAD_CYCLES=3.
// Expected dead-time length follows TEC_PWM_DEADTIME_EN.
module tb_tec_hbridge_pwm;

   localparam int P = 15;
`ifdef TEC_PWM_DEADTIME_EN
   localparam int EXP_DEAD = 3;
`else
   localparam int EXP_DEAD = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, en, cmd_dv, dir;
   logic [3:0] mag;
   logic       o_pwm, o_hpos, o_hneg, o_dead, o_pstart;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   tec_hbridge_pwm #(.WIDTH(4), .DEAD_CYCLES(3)) dut (
      .i_Clock        (clk),
      .i_Reset_n      (rst_n),
      .i_Enable       (en),
      .i_Cmd_DV       (cmd_dv),
      .i_Dir          (dir),
      .i_Mag          (mag),
      .o_Pwm          (o_pwm),
      .o_H_Pos        (o_hpos),
      .o_H_Neg        (o_hneg),
      .o_Dead         (o_dead),
      .o_Period_Start (o_pstart)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pwm"},    o_pwm,    1'b0);
      check({tag, ".hpos"},   o_hpos,   1'b0);
      check({tag, ".hneg"},   o_hneg,   1'b0);
      check({tag, ".dead"},   o_dead,   1'b0);
      check({tag, ".pstart"}, o_pstart, 1'b0);
   endtask

   // Checks one full output period (j = cnt value the outputs reflect) and
   // optionally strobes a command / toggles enable when the live cnt hits the given values.
   task automatic run_period(input string tag, input bit e_pos, input bit e_neg,
                             input int e_dead, input int e_mag,
                             input int s_cnt, input bit s_dir, input logic [3:0] s_mag,
                             input int en_off, input int en_on);
      for (int j = 0; j < P; j++) begin
         bit off, d, drv;
         int nc;
         tick();
         cmd_dv = 1'b0;
         off = (en_off >= 0) && (j >= en_off);
         d   = !off && (j < e_dead) && (e_pos || e_neg);
         drv = !off && !d;
         check($sformatf("%s.j%0d.pstart", tag, j), o_pstart, !off && (j == 0));
         check($sformatf("%s.j%0d.hpos", tag, j),   o_hpos,   drv && e_pos);
         check($sformatf("%s.j%0d.hneg", tag, j),   o_hneg,   drv && e_neg);
         check($sformatf("%s.j%0d.dead", tag, j),   o_dead,   d);
         check($sformatf("%s.j%0d.pwm", tag, j),    o_pwm,    drv && (e_pos || e_neg) && (j < e_mag));
         check($sformatf("%s.j%0d.excl", tag, j),   !(o_hpos && o_hneg), 1'b1);
         nc = (j + 1) % P;
         if (nc == s_cnt) begin
            cmd_dv = 1'b1;
            dir    = s_dir;
            mag    = s_mag;
         end
         if (nc == en_off) en = 1'b0;
         if (nc == en_on)  en = 1'b1;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b1;
      cmd_dv = 1'b0;
      dir    = 1'b0;
      mag    = 4'd0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;

      run_period("boot",        0, 0, 0,        0,  5,  1'b1, 4'd5,  -1, -1);
      run_period("pos5",        1, 0, 0,        5,  7,  1'b0, 4'd10, -1, -1);
      run_period("rev_to_neg",  0, 1, EXP_DEAD, 10, -1, 1'b0, 4'd0,  -1, -1);
      run_period("neg10",       0, 1, 0,        10, 14, 1'b0, 4'd15, -1, -1);
      run_period("neg15_byp",   0, 1, 0,        15, 14, 1'b0, 4'd0,  -1, -1);
      run_period("off_byp",     0, 0, 0,        0,  2,  1'b1, 4'd5,  -1, -1);
      run_period("pos_from_off",1, 0, 0,        5,  4,  1'b0, 4'd10, -1, -1);
      run_period("en_drop",     0, 1, EXP_DEAD, 10, -1, 1'b0, 4'd0,  2,  8);
      run_period("neg_resume",  0, 1, 0,        10, 3,  1'b1, 4'd5,  -1, -1);
      run_period("rev_to_pos",  1, 0, EXP_DEAD, 5,  -1, 1'b0, 4'd0,  -1, -1);
      run_period("pos5_again",  1, 0, 0,        5,  -1, 1'b0, 4'd0,  -1, -1);

      tick();
      tick();
      tick();
      check("midper.hpos", o_hpos, 1'b1);
      check("midper.pwm",  o_pwm,  1'b1);
      rst_n = 1'b0;
      tick();
      check_all_zero("midrst");
      rst_n = 1'b1;
      run_period("post_rst",    0, 0, 0,        0,  -1, 1'b0, 4'd0,  -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tec_hbridge_pwm.md
# tec_hbridge_pwm

Parametrised successor to the 8-bit TEC PWM stage and separate H-bridge direction logic. It combines both into one registered driver. The driver takes a direction and magnitude command from the PID/voltage-mapping path and produces one PWM output plus the two H-bridge leg enables. Commands are double-buffered and applied only at period boundaries. Dead time is inserted on every polarity reversal.

## Interface
- WIDTH, 8: magnitude bits; PWM period P = 2^WIDTH − 1 cycles.
- DEAD_CYCLES, 4: both-legs-off cycles on reversal; legal range 0 ≤ DEAD_CYCLES < P.
- i_Clock  in  1  sole clock.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Enable  in  1  drive permitted; low forces outputs off.
- i_Cmd_DV  in  1  one-cycle strobe; captures i_Dir and i_Mag into the shadow register.
- i_Dir  in  1  1 = heat (h_pos leg), 0 = cool (h_neg leg).
- i_Mag  in  WIDTH  duty in counts; 0 = off, P = 100 %.
- o_Pwm  out  1  registered PWM.
- o_H_Pos  out  1  positive leg enable.
- o_H_Neg  out  1  negative leg enable.
- o_Dead  out  1  high while dead time is being inserted.
- o_Period_Start  out  1  one-cycle pulse; first cycle of each period.

## Operation
- Period counter cnt runs 0..P−1 and wraps to 0. The boundary cycle is cnt == P−1.
- Shadow register {dir, mag} is written on every i_Cmd_DV. The last strobe wins.
- Active register is loaded at the boundary edge.
  - If i_Cmd_DV is high in the boundary cycle, the incoming i_Dir/i_Mag are loaded directly, bypassing the shadow.
  - Otherwise the shadow value is loaded.
- States:
  - OFF: both legs 0, o_Pwm 0.
  - POS: o_H_Pos 1.
  - NEG: o_H_Neg 1.
  - DEAD: both legs 0, o_Pwm 0, o_Dead 1.
- Transitions at the boundary, using the newly loaded active value:
  - mag == 0 → OFF.
  - From OFF with mag ≠ 0 → POS or NEG directly.
  - From POS/NEG, same dir → stay.
  - From POS/NEG, opposite dir with mag ≠ 0 → DEAD, with the dead counter loaded with DEAD_CYCLES.
  - DEAD_CYCLES == 0 → switch directly, no DEAD visit.
- DEAD decrements each cycle. On reaching 0 it enters the pending direction.
- The period counter keeps running during DEAD. The suppressed PWM cycles are lost, not deferred.
- In POS/NEG: o_Pwm ← (cnt < mag). mag == P gives a constant 1 across the whole period.
- i_Enable low: next edge gives state OFF, all outputs 0, dead counter cleared. The counter and shadow keep running.
  - i_Enable rising: OFF is left only at the next boundary.
- Reset mid-operation: everything returns to reset values on the next edge, including abandoning DEAD.
- A command that sets mag > P is clamped to P.

## Timing
- Reset values:
  - Outputs: o_Pwm, o_H_Pos, o_H_Neg, o_Dead, o_Period_Start all 0.
  - Internal: cnt 0, state OFF, shadow and active 0.
- First cycle after reset release: cnt = 0. o_Period_Start asserts on the edge after cnt = 0 is registered.
- All outputs are registered: each output in cycle n reflects state/cnt of cycle n−1. o_Period_Start aligns with o_Pwm's first cycle of the period.
- Command latency: a strobe at cycle k appears on o_Pwm at the first period that starts after the next boundary at or after k. Worst case is P+1 cycles.
- o_H_Pos and o_H_Neg are never both 1 in any cycle, including across reset and enable edges.
- DEAD duration on the outputs is exactly DEAD_CYCLES cycles. The new leg asserts in the cycle after.

## Configuration
- TEC_PWM_DEADTIME_EN defined: DEAD state and dead counter are present as described above.
- Undefined: DEAD is not built, DEAD_CYCLES is ignored, o_Dead ties to 0.
  - A polarity reversal switches the legs at the boundary edge in a single cycle.
  - The mutual-exclusion rule still holds.

## Structure
- Package tec_pwm_pkg holds:
  - the state enum (OFF, POS, NEG, DEAD);
  - DIR_HEAT = 1 and DIR_COOL = 0;
  - the function computing P from WIDTH.
- One sub-module: pwm_period_counter, holding the WIDTH-bit wrap counter. It supplies cnt and the boundary flag.

## Test plan
All scenarios use WIDTH=4, P=15, DEAD_CYCLES=3 unless stated otherwise.
- Reset, then strobe dir=1 mag=5 → from the next period: o_H_Pos=1, o_Pwm high for 5 of every 15 cycles, o_Period_Start every 15 cycles.
- Running dir=1 mag=5, then strobe dir=0 mag=10:
  - At the boundary: o_Dead=1 and both legs 0 for 3 cycles.
  - Then o_H_Neg=1, and o_Pwm high in cycles 3..9 of that period only.
  - Full 10-cycle pulses from the following period onward.
- Strobe exactly in the boundary cycle with mag=15 → the next period has o_Pwm=1 for all 15 cycles.
  - Also, strobe mag=0 → OFF with both legs 0.
- i_Enable dropped mid-DEAD → all outputs 0 on the next edge; i_Enable restored → drive resumes only at the next boundary.
- i_Reset_n low for 1 cycle mid-period while POS → all outputs 0 the following cycle; cnt restarts at 0.
- Build without TEC_PWM_DEADTIME_EN, reverse dir=1→0 → o_H_Pos falls and o_H_Neg rises at the same boundary; o_Dead stays 0 throughout.
